// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory: instruction fetch versus load/store.
// Load/store wins ties until it has been granted MAX_LS_STREAK times in a row while fetch waited.
module mem_arbiter #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int MEM_LATENCY   = 2,
  parameter int MAX_LS_STREAK = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_ack,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be in 1..15");
  end
  if (MAX_LS_STREAK < 1 || MAX_LS_STREAK > 7) begin : g_bad_streak
    $error("mem_arbiter: MAX_LS_STREAK must be in 1..7");
  end

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY - 1);
  localparam logic [2:0] STREAK_MAX = 3'(MAX_LS_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  grant_if, grant_ls;
  logic [3:0]            lat_cnt;
  logic [2:0]            streak;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, ls_rdata_q;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    case (state)
      IDLE: begin
        if (ls_req && !(if_req && streak == STREAK_MAX)) begin
          grant_ls = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
        if (grant_ls || grant_if) state_nxt = ACCESS;
      end
      ACCESS:  if (lat_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      streak     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_q    <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ls) begin
        addr_q  <= ls_addr;
        wdata_q <= ls_wdata;
        we_q    <= ls_we;
        owner_q <= 1'b1;
        lat_cnt <= LAT_INIT;
        // Streak only grows while fetch is actually waiting; an uncontested grant restarts it.
        if (!if_req)                 streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + 3'd1;
      end else if (grant_if) begin
        addr_q  <= if_addr;
        wdata_q <= '0;
        we_q    <= 1'b0;
        owner_q <= 1'b0;
        lat_cnt <= LAT_INIT;
        streak  <= '0;
      end
      if (state == ACCESS) begin
        if (lat_cnt == 4'd0) begin
          if (!owner_q)   if_rdata_q <= mem_rdata;
          else if (!we_q) ls_rdata_q <= mem_rdata;
        end else begin
          lat_cnt <= lat_cnt - 4'd1;
        end
      end
    end
  end

  // Enables decode from state alone, so an asynchronous reset removes them at once.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state == ACCESS) || (state == DONE);
  assign owner     = owner_q;
  assign if_ack    = (state == DONE) && !owner_q;
  assign ls_ack    = (state == DONE) && owner_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations for latency, grant order, withdrawal and reset abort.
module tb_mem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int LAT  = 2;
  localparam int MAXS = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] if_addr = '0, ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          if_ack, ls_ack, mem_en, mem_we, busy, owner;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem_arr [256];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .MAX_LS_STREAK(MAXS)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;
  assign mem_rdata = mem_arr[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_rem counts the cycles left in the current transaction
  // (LAT access cycles followed by one ack cycle); 0 means the arbiter is free.
  int            m_rem = 0;
  int            m_streak = 0;
  logic          m_owner = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_if_rdata = '0, m_ls_rdata = '0;

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_rem = 0; m_streak = 0; m_owner = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_ls_rdata = '0;
      end else begin
        if (m_rem == 0) begin
          if (ls_req && !(if_req && m_streak == MAXS)) begin
            m_owner = 1'b1; m_addr = ls_addr; m_we = ls_we; m_wdata = ls_wdata;
            m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            m_rem = LAT + 1;
          end else if (if_req) begin
            m_owner = 1'b0; m_addr = if_addr; m_we = 1'b0; m_wdata = '0;
            m_streak = 0;
            m_rem = LAT + 1;
          end
        end else begin
          if (m_rem == 2 && !m_we) begin
            if (m_owner) m_ls_rdata = mem_arr[m_addr];
            else         m_if_rdata = mem_arr[m_addr];
          end
          m_rem--;
        end
        if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("mem_en", mem_en, (m_rem >= 2));
        check("mem_we", mem_we, (m_rem >= 2) && m_we);
        if (m_rem >= 2) check("mem_addr", mem_addr, m_addr);
        if (m_rem >= 2 && m_we) check("mem_wdata", mem_wdata, m_wdata);
        check("busy", busy, (m_rem >= 1));
        check("if_ack", if_ack, (m_rem == 1) && !m_owner);
        check("ls_ack", ls_ack, (m_rem == 1) && m_owner);
        check("owner", owner, m_owner);
        check("if_rdata", if_rdata, m_if_rdata);
        check("ls_rdata", ls_rdata, m_ls_rdata);
      end
    end
  end

  task automatic to_phase();
    @(posedge clock);
    #2;
  endtask

  task automatic transact(input logic is_ls, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int lat, output logic saw_we);
    logic done;
    done = 1'b0; lat = 0; saw_we = 1'b0;
    if (is_ls) begin ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; end
    else       begin if_req = 1'b1; if_addr = addr; end
    while (!done && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (mem_en && mem_we) saw_we = 1'b1;
      if (is_ls ? ls_ack : if_ack) done = 1'b1;
    end
    check("ack_within_budget", done, 1'b1);
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    to_phase();
  endtask

  initial begin
    int   lat, cnt;
    logic saw_we;
    logic got [$];
    logic exp_order [6];
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    mem_arr[8'h10] = 16'hBEEF;
    mem_arr[8'h30] = 16'hA5A5;
    mem_arr[8'h40] = 16'h5A5A;

    // Reset and idle
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (mem_en || if_ack || ls_ack || busy) cnt++;
    end
    check("idle_activity", cnt, 0);
    check("idle_if_rdata", if_rdata, 16'h0);
    to_phase();

    // Single fetch: ack three edges after the request is first seen
    transact(1'b0, 1'b0, 8'h10, 16'h0, lat, saw_we);
    check("fetch_latency", lat, 3);
    check("fetch_data", if_rdata, 16'hBEEF);
    check("fetch_no_write", saw_we, 1'b0);

    // Store then load on the same address
    transact(1'b1, 1'b1, 8'h20, 16'h1234, lat, saw_we);
    check("store_wrote", saw_we, 1'b1);
    check("store_keeps_ls_rdata", ls_rdata, 16'h0);
    transact(1'b1, 1'b0, 8'h20, 16'h0, lat, saw_we);
    check("load_data", ls_rdata, 16'h1234);
    check("load_latency", lat, 3);

    // Both requesters held: LS, LS, IF repeating
    if_req = 1'b1; if_addr = 8'h30;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h40;
    for (int c = 0; c < 60 && got.size() < 6; c++) begin
      @(negedge clock);
      if (if_ack) got.push_back(1'b0);
      if (ls_ack) got.push_back(1'b1);
    end
    if_req = 1'b0; ls_req = 1'b0;
    check("grant_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      check($sformatf("grant_order_%0d", i), got[i], exp_order[i]);
    check("prio_if_data", if_rdata, 16'hA5A5);
    check("prio_ls_data", ls_rdata, 16'h5A5A);
    to_phase();

    // Withdrawal one cycle after grant
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h10;
    @(posedge clock);
    @(posedge clock);
    #2 ls_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ls_ack) cnt++;
    end
    check("withdraw_ack_count", cnt, 1);
    check("withdraw_idle", busy, 1'b0);
    check("withdraw_data", ls_rdata, 16'hBEEF);
    to_phase();

    // Reset during the second access cycle
    if_req = 1'b1; if_addr = 8'h40;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0; if_req = 1'b0;
    #1;
    check("abort_mem_en", mem_en, 1'b0);
    check("abort_mem_we", mem_we, 1'b0);
    check("abort_busy", busy, 1'b0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (if_ack || ls_ack) cnt++;
    end
    check("abort_no_ack", cnt, 0);
    check("abort_if_rdata", if_rdata, 16'h0);
    to_phase();
    transact(1'b0, 1'b0, 8'h10, 16'h0, lat, saw_we);
    check("post_reset_latency", lat, 3);
    check("post_reset_data", if_rdata, 16'hBEEF);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port main memory between the instruction-fetch path and the data load/store path of the multi-cycle CPU.
- Uses a request/ack handshake on each side and a fixed-latency memory access sequence.
- Load/store has priority over fetch, bounded by a streak limit so fetch is never starved.
- Sits between the control/datapath stages (fetch, load, store) and the memory array.

Parameters:
ADDR_WIDTH, 8, memory address width
DATA_WIDTH, 16, memory word width
MEM_LATENCY, 2, cycles mem_en is held per access; legal range 1..15 (elaboration error otherwise)
MAX_LS_STREAK, 2, consecutive load/store grants allowed while fetch waits; legal range 1..7

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch requests a read
if_addr  in  ADDR_WIDTH  fetch address
if_ack  out  1  one-cycle pulse: fetch transaction complete, if_rdata valid
if_rdata  out  DATA_WIDTH  registered fetch read data
ls_req  in  1  load/store requests an access
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_WIDTH  load/store address
ls_wdata  in  DATA_WIDTH  store data
ls_ack  out  1  one-cycle pulse: load/store complete
ls_rdata  out  DATA_WIDTH  registered load data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid by last access cycle
busy  out  1  high in ACCESS and DONE
owner  out  1  0 = fetch, 1 = load/store; owner of current/last transaction

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; all outputs 0.
  - Streak counter and latency counter cleared; rdata registers cleared.
  - Reset during ACCESS drops mem_en/mem_we immediately, without waiting for a clock edge. No ack is issued for an aborted transaction.
- FSM: IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered or decoded from state only; there is no combinational path from the req inputs.
- IDLE, arbitration at the clock edge:
  - Neither req: stay in IDLE.
  - Only one req: grant it.
  - Both req: grant load/store unless streak == MAX_LS_STREAK, in which case grant fetch.
  - On grant: latch addr, we (forced 0 for fetch) and wdata; set owner; load latency counter with MEM_LATENCY-1; go to ACCESS.
- Streak counter:
  - Increments on a load/store grant made while if_req = 1.
  - Clears on any fetch grant, and on a load/store grant made while if_req = 0.
  - Saturates at MAX_LS_STREAK.
- ACCESS:
  - mem_en = 1, mem_we = latched we, mem_addr and mem_wdata = latched values, all held stable for exactly MEM_LATENCY cycles.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture mem_rdata into the owner's rdata register (loads and fetches only; ls_rdata is unchanged on a store), then go to DONE.
- DONE:
  - Owner's ack = 1 for exactly one cycle; mem_en = 0; go to IDLE.
- Latency: grant edge at cycle N -> mem_en high for cycles N+1..N+MEM_LATENCY -> ack in cycle N+MEM_LATENCY+1. Throughput is one transaction per MEM_LATENCY+2 cycles.
- Handshake:
  - Requester holds req, addr, we and wdata stable until its ack.
  - Inputs are sampled only at the grant edge; later changes are ignored.
  - req withdrawn mid-transaction: the transaction still completes and ack still pulses.
  - req held high through ack: treated as a new request at the next IDLE edge.
- Simultaneous events: a req that rises in the DONE cycle is arbitrated in IDLE on the following edge. Both acks are never high together.
- Output stability: rdata registers hold their value until the next completing read for the same requester.

Test Plan:
- Reset/idle: hold reset low 3 cycles, then release with no requests for 5 cycles -> mem_en, if_ack, ls_ack and busy stay 0; if_rdata = 0.
- Single fetch: MEM_LATENCY=2, if_req with if_addr=0x10, memory[0x10]=0xBEEF -> mem_en high 2 cycles with mem_addr=0x10 and mem_we=0; if_ack pulses 3 cycles after the grant edge with if_rdata=0xBEEF.
- Store then load: ls store addr 0x20, data 0x1234; then ls load addr 0x20 -> first transaction has mem_we=1 and ls_rdata unchanged; second returns ls_rdata=0x1234 with ls_ack.
- Priority/starvation: MAX_LS_STREAK=2, if_req and ls_req held high continuously -> grant order LS, LS, IF, LS, LS, IF; owner sequence 1,1,0,1,1,0.
- Withdrawal: ls_req dropped 1 cycle after grant -> transaction completes and ls_ack still pulses once; with no further reqs, FSM returns to IDLE.
- Reset mid-access: assert reset during the second ACCESS cycle -> mem_en drops immediately (before the next edge); no ack; after release, a new fetch completes normally.
